irq_timer_ctrl: RTL and testbench
=================================

# irq_timer_ctrl

Memory-mapped interrupt controller and compare timer that sits on the OpenMIPS data-RAM port alongside `data_memory`. It consumes core load/store requests that hit its address window and drives the core's six hardware interrupt inputs `int_i[5:0]`. It latches edge-triggered external sources, applies a software mask, and supplies a free-running compare timer on interrupt line 5.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_2000, window base; 32-byte aligned; decode on `addr_i[31:5]`
- `NUM_EXT`, 5, external sources mapped to `int_o[NUM_EXT-1:0]`; fixed at 5 in this design

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ce_i`  in  1  core RAM chip enable (`ram_ce_o`)
- `we_i`  in  1  write enable (`ram_we_o`)
- `addr_i`  in  32  byte address (`ram_addr_o`)
- `sel_i`  in  4  byte lanes (`ram_sel_o`); bit3 = data[31:24]
- `data_i`  in  32  write data (`ram_data_o`)
- `data_o`  out  32  registered read data
- `hit_o`  out  1  registered: previous-cycle access decoded to this window; steers the wrapper's read mux
- `irq_src_i`  in  5  external sources, synchronous to `clk`, rising-edge sensitive
- `int_o`  out  6  to core `int_i`; `int_o[k] = pend[k] & mask[k]`
- `timer_int_o`  out  1  `pend[5]` unmasked, for debug/trace

## Operation
Register map, word offsets; unlisted offsets read 0 and ignore writes:
- 0x00 PEND[5:0]: read pending; write-1-to-clear in lane 0 only.
- 0x04 MASK[5:0]: R/W, lane 0.
- 0x08 CNT[31:0]: R/W, byte-lane writes.
- 0x0C CMP[31:0]: R/W, byte-lane writes.
- 0x10 CTRL[1:0]: R/W, lane 0. Bit0 = EN (timer run); bit1 = AR (auto-reload).

Access and reset:
- An access is `ce_i & (addr_i[31:5] == BASE_ADDR[31:5])`. A write also requires `we_i`.
- Reset values: PEND=0, MASK=0, CNT=0, CMP=32'hFFFF_FFFF, CTRL=0, `data_o`=0, `hit_o`=0, `int_o`=0, `timer_int_o`=0.

Edge detection:
- `src_q` is a 1-cycle delayed copy of `irq_src_i`, reset to 0.
- A rise on source k is `irq_src_i[k] & ~src_q[k]`; it sets `PEND[k]`.
- A source held high sets PEND only once. After PEND is cleared, it does not re-set until a new rising edge.

Timer:
- While EN=1, CNT increments by 1 every cycle, modulo 2^32.
- A match occurs when EN=1 and CNT==CMP; the match sets `PEND[5]`.
- On a match with AR=1, the next CNT is 0. With AR=0, CNT continues to CMP+1 and wraps through 0.
- While EN=0, CNT holds.

Precedence and simultaneous events:
- Set beats W1C in the same cycle: PEND stays 1.
- A CNT write beats the increment; no match is evaluated that cycle.
- A CMP write takes effect from the next cycle.
- Reset mid-operation returns every register to its reset value the following edge; there is no partial state.

## Timing
- Read latency is 1 cycle. `data_o` and `hit_o` are valid on the edge after the `ce_i` cycle, matching `data_memory`.
- `data_o` holds its last value on non-hit cycles.
- Writes update the register at the edge of the access cycle. A read of the same offset in the next cycle returns the new value.
- `int_o` and `timer_int_o` are registered:
  - external source: edge at `irq_src_i` in cycle N gives `PEND` and `int_o` high from cycle N+1;
  - timer: CNT==CMP in cycle N gives `int_o[5]` high from cycle N+1.
- No stall or handshake: every hit access completes in one cycle, with no back-pressure.

## Configuration
- `IRQ_TIMER_EN` defined: timer logic (CNT, CMP, CTRL, PEND[5]) present as above.
- Not defined:
  - CNT, CMP and CTRL are removed;
  - offsets 0x08–0x10 read 0 and ignore writes;
  - `PEND[5]`, `int_o[5]` and `timer_int_o` are tied 0;
  - external-source logic is unchanged.

## Test plan
- Reset then idle: `int_o`=0, reads of 0x00/0x04/0x08/0x10 return 0, read of 0x0C returns 32'hFFFF_FFFF, `hit_o` high one cycle after each read.
- External edge: MASK=6'h08, pulse `irq_src_i[3]` for 1 cycle -> `int_o`=6'b001000 next cycle and held. Write 0x00 with 8'h08 -> `int_o`=0 next cycle. Holding the source high afterwards must not re-set PEND.
- Mask gating: MASK=0, pulse `irq_src_i[0]` -> PEND reads 6'h01, `int_o`=0. Then write MASK=1 -> `int_o[0]`=1 next cycle.
- Timer auto-reload: CMP=9, CTRL=3, MASK=6'h20 -> `int_o[5]` rises 10 cycles after the CTRL write, CNT reads 0 immediately after the match, and the next match follows 10 cycles later.
- Simultaneous W1C and set: a W1C of PEND[5] in the same cycle as a timer match leaves PEND[5]=1. A CNT write of 0 in a match cycle produces no pending.
- Build without `IRQ_TIMER_EN`: the CTRL=1 write is ignored, 0x08 reads 0, and `int_o[5]` stays 0 for 100 cycles.

Source files
------------

// File: rtl/irq_timer_ctrl.sv
// Memory-mapped interrupt controller with an edge-latched external source bank and compare timer.
// Define IRQ_TIMER_EN to build the timer (CNT/CMP/CTRL, PEND[5]); without it those offsets read 0.
module irq_timer_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          NUM_EXT   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic               hit_o,
  input  logic [NUM_EXT-1:0] irq_src_i,
  output logic [5:0]         int_o,
  output logic               timer_int_o
);

  // Bus protocol: no valid/ready pair. ce_i qualifies a request, every hit
  // completes in its own cycle, and hit_o/data_o follow one edge later.
  logic               acc;
  logic               wr;
  logic [2:0]         off;
  logic               timer_set;
  logic [31:0]        tmr_rd;
  logic [31:0]        rd_val;
  logic               unused_bits;

  logic [NUM_EXT-1:0] src_q, src_d;
  logic [5:0]         pend_q, pend_d;
  logic [5:0]         mask_q, mask_d;
  logic [5:0]         int_q, int_d;
  logic [31:0]        data_q, data_d;
  logic               hit_q, hit_d;

  assign acc = ce_i & (addr_i[31:5] == BASE_ADDR[31:5]);
  assign wr  = acc & we_i;
  assign off = addr_i[4:2];

`ifdef IRQ_TIMER_EN
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        match;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  lanes);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    cnt_d  = cnt_q;
    cmp_d  = cmp_q;
    ctrl_d = ctrl_q;
    match  = 1'b0;
    // A software CNT write overrides both the increment and the compare.
    if (wr && off == 3'd2) begin
      cnt_d = merge_lanes(cnt_q, data_i, sel_i);
    end else if (ctrl_q[0]) begin
      match = (cnt_q == cmp_q);
      cnt_d = (match && ctrl_q[1]) ? 32'd0 : cnt_q + 32'd1;
    end
    if (wr && off == 3'd3) cmp_d = merge_lanes(cmp_q, data_i, sel_i);
    if (wr && off == 3'd4 && sel_i[0]) ctrl_d = data_i[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 32'd0;
      cmp_q  <= 32'hFFFF_FFFF;
      ctrl_q <= 2'b00;
    end else begin
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      ctrl_q <= ctrl_d;
    end
  end

  always_comb begin
    tmr_rd = 32'd0;
    case (off)
      3'd2:    tmr_rd = cnt_q;
      3'd3:    tmr_rd = cmp_q;
      3'd4:    tmr_rd = {30'd0, ctrl_q};
      default: tmr_rd = 32'd0;
    endcase
  end

  assign timer_set   = match;
  assign unused_bits = ^addr_i[1:0];
`else
  assign timer_set   = 1'b0;
  assign tmr_rd      = 32'd0;
  assign unused_bits = ^{addr_i[1:0], data_i[31:6], sel_i[3:1]};
`endif

  always_comb begin
    src_d  = irq_src_i;
    pend_d = pend_q;
    mask_d = mask_q;
    hit_d  = acc;
    data_d = data_q;
    rd_val = 32'd0;
    case (off)
      3'd0:    rd_val = {26'd0, pend_q};
      3'd1:    rd_val = {26'd0, mask_q};
      default: rd_val = tmr_rd;
    endcase
    if (acc && !we_i) data_d = rd_val;
    if (wr && off == 3'd0 && sel_i[0]) pend_d = pend_q & ~data_i[5:0];
    if (wr && off == 3'd1 && sel_i[0]) mask_d = data_i[5:0];
    // Sets are applied after the clear so a same-cycle event is never lost.
    pend_d[NUM_EXT-1:0] = pend_d[NUM_EXT-1:0] | (irq_src_i & ~src_q);
    pend_d[5]           = pend_d[5] | timer_set;
    int_d               = pend_d & mask_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= '0;
      pend_q <= 6'd0;
      mask_q <= 6'd0;
      int_q  <= 6'd0;
      data_q <= 32'd0;
      hit_q  <= 1'b0;
    end else begin
      src_q  <= src_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      int_q  <= int_d;
      data_q <= data_d;
      hit_q  <= hit_d;
    end
  end

  assign data_o      = data_q;
  assign hit_o       = hit_q;
  assign int_o       = int_q;
  assign timer_int_o = pend_q[5];

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Randomized bench for irq_timer_ctrl against a transaction-level model of the register map.
module tb_irq_timer_ctrl;

  localparam logic [31:0] BASE = 32'h0000_2000;
`ifdef IRQ_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic [4:0]  src;
  logic [31:0] data_o;
  logic        hit_o;
  logic [5:0]  int_o;
  logic        timer_int_o;

  always #5 clk = ~clk;

  irq_timer_ctrl #(.BASE_ADDR(BASE), .NUM_EXT(5)) dut (
    .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(wdata), .data_o(data_o), .hit_o(hit_o), .irq_src_i(src),
    .int_o(int_o), .timer_int_o(timer_int_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int          checks = 0;
  int          failures = 0;
  logic [5:0]  m_pend, m_mask;
  logic [31:0] m_cnt, m_cmp, m_data;
  logic        m_en, m_ar, m_hit;
  logic [4:0]  m_src;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] o);
    case (o)
      3'd0:    return {26'd0, m_pend};
      3'd1:    return {26'd0, m_mask};
      3'd2:    return TMR ? m_cnt : 32'd0;
      3'd3:    return TMR ? m_cmp : 32'd0;
      3'd4:    return TMR ? {30'd0, m_ar, m_en} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Applies one bus cycle worth of register-map rules to the model state.
  task automatic model_step();
    logic       a, w, match;
    logic [2:0] o;
    logic [5:0] np;
    if (rst) begin
      m_pend = 6'd0; m_mask = 6'd0; m_cnt = 32'd0; m_cmp = 32'hFFFF_FFFF;
      m_en = 1'b0; m_ar = 1'b0; m_src = 5'd0; m_hit = 1'b0; m_data = 32'd0;
      exp_q.delete();
      return;
    end
    a = ce && (addr[31:5] == BASE[31:5]);
    w = a && we;
    o = addr[4:2];
    m_hit = a;
    if (a && !we) exp_q.push_back(m_read(o));
    match = TMR && m_en && !(w && o == 3'd2) && (m_cnt == m_cmp);
    np = m_pend;
    if (w && o == 3'd0 && sel[0]) np = np & ~wdata[5:0];
    np[4:0] = np[4:0] | (src & ~m_src);
    if (match) np[5] = 1'b1;
    m_pend = np;
    m_src  = src;
    if (w && o == 3'd1 && sel[0]) m_mask = wdata[5:0];
    if (TMR) begin
      if (w && o == 3'd2) m_cnt = lanes(m_cnt, wdata, sel);
      else if (m_en) m_cnt = (match && m_ar) ? 32'd0 : m_cnt + 32'd1;
      if (w && o == 3'd3) m_cmp = lanes(m_cmp, wdata, sel);
      if (w && o == 3'd4 && sel[0]) begin
        m_en = wdata[0];
        m_ar = wdata[1];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic c, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    ce = c; we = w; addr = a; sel = s; wdata = d;
    @(posedge clk);
    model_step();
    #1;
    if (exp_q.size() > 0) m_data = exp_q.pop_front();
    check_val("hit_o", {31'd0, hit_o}, {31'd0, m_hit});
    check_val("data_o", data_o, m_data);
    check_val("int_o", {26'd0, int_o}, {26'd0, m_pend & m_mask});
    check_val("timer_int_o", {31'd0, timer_int_o}, {31'd0, m_pend[5]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
  endtask

  task automatic wr_reg(input logic [4:0] o, input logic [31:0] d);
    cycle(1'b1, 1'b1, BASE + {27'd0, o}, 4'hF, d);
  endtask

  task automatic rd_reg(input logic [4:0] o);
    cycle(1'b1, 1'b0, BASE + {27'd0, o}, 4'h0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first;
    rst = 1'b1; src = 5'd0;
    idle(3);
    rst = 1'b0;

    // Reset state read-back
    rd_reg(5'h00); check_val("rst_pend", data_o, 32'd0);
    rd_reg(5'h04); check_val("rst_mask", data_o, 32'd0);
    rd_reg(5'h08); check_val("rst_cnt", data_o, 32'd0);
    rd_reg(5'h0C); check_val("rst_cmp", data_o, TMR ? 32'hFFFF_FFFF : 32'd0);
    rd_reg(5'h10); check_val("rst_ctrl", data_o, 32'd0);

    // External edge, hold, W1C, no re-set while held
    wr_reg(5'h04, 32'h08);
    src = 5'b01000; idle(1); src = 5'd0;
    check_val("ext_set", {26'd0, int_o}, 32'h08);
    idle(3);
    check_val("ext_held", {26'd0, int_o}, 32'h08);
    wr_reg(5'h00, 32'h08);
    check_val("ext_w1c", {26'd0, int_o}, 32'h00);
    src = 5'b01000; idle(2);
    wr_reg(5'h00, 32'h08);
    idle(5);
    check_val("ext_hold_no_reset", {26'd0, int_o}, 32'h00);
    src = 5'd0; idle(1);

    // Mask gating
    wr_reg(5'h04, 32'h00);
    src = 5'b00001; idle(1); src = 5'd0;
    rd_reg(5'h00); check_val("mask_pend", data_o, 32'h01);
    check_val("mask_gated", {26'd0, int_o}, 32'h00);
    wr_reg(5'h04, 32'h01);
    check_val("mask_open", {26'd0, int_o}, 32'h01);
    wr_reg(5'h00, 32'h3F);

    // Timer auto-reload: CMP=9, counting starts the cycle after the CTRL write
    wr_reg(5'h0C, 32'd9);
    wr_reg(5'h04, 32'h20);
    wr_reg(5'h10, 32'h3);
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      idle(1);
      if (int_o[5]) first = i;
    end
    check_val("tmr_first_match", first, TMR ? 32'd10 : 32'd0);
    rd_reg(5'h08); check_val("cnt_after_match", data_o, 32'd0);
    wr_reg(5'h00, 32'h20);
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      idle(1);
      if (int_o[5]) first = i;
    end
    // 10-cycle period minus the read and the clear already spent
    check_val("tmr_second_match", first, TMR ? 32'd8 : 32'd0);

    // W1C in the same cycle as a match: set wins
    wr_reg(5'h10, 32'h0);
    wr_reg(5'h08, 32'd5);
    wr_reg(5'h0C, 32'd7);
    wr_reg(5'h00, 32'h20);
    wr_reg(5'h10, 32'h1);
    idle(2);
    wr_reg(5'h00, 32'h20);
    check_val("w1c_vs_set", {31'd0, int_o[5]}, {31'd0, TMR});

    // CNT write in the match cycle suppresses the match
    wr_reg(5'h10, 32'h0);
    wr_reg(5'h00, 32'h20);
    wr_reg(5'h08, 32'd3);
    wr_reg(5'h0C, 32'd4);
    wr_reg(5'h10, 32'h1);
    idle(1);
    wr_reg(5'h08, 32'd0);
    check_val("cnt_wr_no_match", {31'd0, int_o[5]}, 32'd0);
    idle(3);
    check_val("cnt_wr_still_clear", {31'd0, int_o[5]}, 32'd0);
    wr_reg(5'h10, 32'h0);

    // CTRL write ignored when the timer is not built
    wr_reg(5'h10, 32'h1);
    rd_reg(5'h10); check_val("ctrl_readback", data_o, TMR ? 32'd1 : 32'd0);
    idle(100);
    wr_reg(5'h10, 32'h0);

    // Reset mid-operation
    wr_reg(5'h04, 32'h3F);
    src = 5'b10110; idle(1);
    rst = 1'b1; idle(1); rst = 1'b0; src = 5'd0;
    check_val("midrst_int", {26'd0, int_o}, 32'd0);
    rd_reg(5'h04); check_val("midrst_mask", data_o, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int op;
      logic [2:0]  o;
      logic [31:0] d;
      if ($urandom_range(0, 2) == 0) src[$urandom_range(0, 4)] = ~src[$urandom_range(0, 4)];
      rst = ($urandom_range(0, 299) == 0);
      op = $urandom_range(0, 9);
      o  = 3'($urandom_range(0, 7));
      d  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (op < 3) begin
        idle(1);
      end else if (op < 6) begin
        cycle(1'b1, 1'b0, BASE + {27'd0, o, 2'($urandom_range(0, 3))}, 4'($urandom), 32'd0);
      end else if (op < 9) begin
        cycle(1'b1, 1'b1, BASE + {27'd0, o, 2'b00}, 4'($urandom_range(0, 15)), d);
      end else begin
        cycle(1'b1, 1'($urandom), BASE ^ (32'h20 << $urandom_range(0, 26)), 4'hF, d);
      end
    end
    rst = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
